// File: rtl/aib_osc_tmr_pkg.sv
// Shared types and limits for the aux-oscillator interval timer arbiter.
package aib_osc_tmr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} osc_tmr_st_e;

    localparam int NREQ_MAX = 8;
    localparam int PRESC_W  = 4;

endpackage

// File: rtl/aib_osc_tmr_arb_if.sv
// Requester-side bundle for aib_osc_tmr_arb; presc_sel exists only with AIB_OSC_TMR_PRESCALE_EN.
interface aib_osc_tmr_arb_if
    import aib_osc_tmr_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
);

    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] cnt_val;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [CNT_W-1:0]      cur_cnt;
`ifdef AIB_OSC_TMR_PRESCALE_EN
    logic [PRESC_W-1:0]    presc_sel;

    modport master (output req, cnt_val, presc_sel, input gnt, done, busy, cur_cnt);
    modport slave  (input req, cnt_val, presc_sel, output gnt, done, busy, cur_cnt);
`else
    modport master (output req, cnt_val, input gnt, done, busy, cur_cnt);
    modport slave  (input req, cnt_val, output gnt, done, busy, cur_cnt);
`endif

endinterface

// File: rtl/aib_osc_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
module aib_osc_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);

    int               kk;
    logic [IDX_W-1:0] k;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        kk      = 0;
        k       = '0;
        for (int i = 0; i < NREQ; i++) begin
            kk = int'(rr_ptr) + i;
            if (kk >= NREQ) kk = kk - NREQ;
            k = IDX_W'(kk);
            if (!win_any && req[k]) begin
                win_any    = 1'b1;
                win_oh[k]  = 1'b1;
                win_idx    = k;
            end
        end
    end

endmodule

// File: rtl/aib_osc_tmr_arb.sv
// Round-robin shared interval timer on osc_clk: grant, count down, one-cycle done pulse.
// Optional tick prescaler enabled by macro AIB_OSC_TMR_PRESCALE_EN.
module aib_osc_tmr_arb
    import aib_osc_tmr_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input logic              osc_clk,
    input logic              osc_rst,
    aib_osc_tmr_arb_if.slave tmr
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("aib_osc_tmr_arb: NREQ out of range");
    end

    osc_tmr_st_e      st_q, st_d;
    logic [IDX_W-1:0] own_q, own_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic [CNT_W-1:0] cnt_arr [NREQ];
    logic             tick;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NREQ - 1) return '0;
        return idx + 1'b1;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign cnt_arr[g] = tmr.cnt_val[g*CNT_W +: CNT_W];
    end

    aib_osc_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req     (tmr.req),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

`ifdef AIB_OSC_TMR_PRESCALE_EN
    // Divider restarts at grant so the first tick lands 2**presc_sel cycles after gnt.
    logic [PRESC_W-1:0] presc_q;
    logic [14:0]        pcnt_q;
    logic [14:0]        pcnt_lim;

    assign pcnt_lim = 15'((32'd1 << presc_q) - 32'd1);
    assign tick     = (pcnt_q == pcnt_lim);

    always_ff @(posedge osc_clk or posedge osc_rst) begin
        if (osc_rst) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else if (st_q == IDLE && win_any) begin
            presc_q <= tmr.presc_sel;
            pcnt_q  <= '0;
        end else if (st_q == RUN) begin
            pcnt_q <= tick ? 15'd0 : pcnt_q + 15'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        st_d     = st_q;
        own_d    = own_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        busy_d   = busy_q;
        unique case (st_q)
            IDLE: begin
                if (win_any) begin
                    st_d   = RUN;
                    own_d  = win_idx;
                    gnt_d  = win_oh;
                    busy_d = 1'b1;
                    cnt_d  = cnt_arr[win_idx];
                end
            end
            RUN: begin
                // A dropped request beats a simultaneous expiry: no done pulse.
                if (!tmr.req[own_q]) begin
                    st_d     = IDLE;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    rr_ptr_d = next_ptr(own_q);
                end else if (tick) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        st_d     = DONE;
                        gnt_d    = '0;
                        done_d   = gnt_q;
                        rr_ptr_d = next_ptr(own_q);
                    end
                end
            end
            DONE: begin
                st_d   = IDLE;
                busy_d = 1'b0;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge osc_clk or posedge osc_rst) begin
        if (osc_rst) begin
            st_q     <= IDLE;
            own_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            own_q    <= own_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign tmr.gnt     = gnt_q;
    assign tmr.done    = done_q;
    assign tmr.busy    = busy_q;
    assign tmr.cur_cnt = cnt_q;

endmodule

// File: tb/tb_aib_osc_tmr_arb.sv
// Bench for aib_osc_tmr_arb: timeline model of grant/countdown/done plus directed scenarios.
module tb_aib_osc_tmr_arb;

    localparam int NREQ  = 4;
    localparam int CNT_W = 16;
    localparam int VW    = NREQ * CNT_W;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    aib_osc_tmr_arb_if #(.NREQ(NREQ), .CNT_W(CNT_W)) tmr ();

    aib_osc_tmr_arb #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .osc_clk (clk),
        .osc_rst (rst),
        .tmr     (tmr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: owner granted at t=0, holds gnt for len+1 cycles, done at t=len+1.
    int m_own = -1;
    int m_t   = 0;
    int m_len = 0;
    int m_ptr = 0;
    int m_k   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_own = -1;
            m_t   = 0;
            m_len = 0;
            m_ptr = 0;
        end else if (m_own >= 0) begin
            if (m_t <= m_len && !tmr.req[m_own[1:0]]) begin
                m_ptr = (m_own + 1) % NREQ;
                m_own = -1;
            end else begin
                m_t++;
                if (m_t == m_len + 1) m_ptr = (m_own + 1) % NREQ;
                if (m_t == m_len + 2) m_own = -1;
            end
        end else if (tmr.req != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                m_k = (m_ptr + i) % NREQ;
                if (m_own < 0 && tmr.req[m_k[1:0]]) m_own = m_k;
            end
            m_t   = 0;
            m_len = int'(CNT_W'(tmr.cnt_val >> (m_own * CNT_W)));
        end
    end

    logic [NREQ-1:0]  e_gnt, e_done, prev_gnt;
    logic             e_busy;
    logic [CNT_W-1:0] e_cur;
    int               glog[$];
    int               gtime[$];
    int               done_seen = 0;

    initial prev_gnt = '0;

    always @(negedge clk) begin
        e_gnt  = '0;
        e_done = '0;
        e_busy = 1'b0;
        e_cur  = '0;
        if (m_own >= 0) begin
            if (m_t <= m_len) begin
                e_gnt  = NREQ'(1 << m_own);
                e_busy = 1'b1;
                e_cur  = CNT_W'(m_len - m_t);
            end else if (m_t == m_len + 1) begin
                e_done = NREQ'(1 << m_own);
                e_busy = 1'b1;
            end
        end
        check("gnt",  32'(tmr.gnt),     32'(e_gnt));
        check("done", 32'(tmr.done),    32'(e_done));
        check("busy", 32'(tmr.busy),    32'(e_busy));
        check("cur",  32'(tmr.cur_cnt), 32'(e_cur));
        check("gnt_done_overlap", 32'(tmr.gnt & tmr.done), 32'd0);
        check("gnt_onehot0", 32'($onehot0(tmr.gnt)), 32'd1);
        if (tmr.gnt != '0 && prev_gnt == '0) begin
            for (int i = 0; i < NREQ; i++) if (tmr.gnt[i[1:0]]) glog.push_back(i);
            gtime.push_back(cyc);
        end
        if (tmr.done != '0) done_seen++;
        prev_gnt = tmr.gnt;
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_cnt(input int i, input int v);
        logic [VW-1:0] msk;
        msk         = VW'({CNT_W{1'b1}}) << (i * CNT_W);
        tmr.cnt_val = (tmr.cnt_val & ~msk) | (VW'(CNT_W'(v)) << (i * CNT_W));
    endtask

    task automatic wait_gnt(input int idx);
        int n;
        n = 0;
        do begin
            nxt();
            n++;
        end while (tmr.gnt[idx[1:0]] !== 1'b1 && n < 20);
        check("wait_gnt", 32'(tmr.gnt[idx[1:0]]), 32'd1);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int d0;

    initial begin
        rst         = 1'b1;
        tmr.req     = '0;
        tmr.cnt_val = '0;
`ifdef AIB_OSC_TMR_PRESCALE_EN
        tmr.presc_sel = '0;
`endif
        nxt();
        nxt();
        check("rst_gnt",  32'(tmr.gnt),     32'd0);
        check("rst_busy", 32'(tmr.busy),    32'd0);
        check("rst_cur",  32'(tmr.cur_cnt), 32'd0);
        rst = 1'b0;

        // Single requester, interval 3
        nxt();
        set_cnt(0, 3);
        tmr.req = 4'b0001;
        nxt();
        check("t1_gnt", 32'(tmr.gnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("t1_cur", 32'(tmr.cur_cnt), 32'(3 - i));
            if (i < 3) nxt();
        end
        nxt();
        check("t1_done", 32'(tmr.done), 32'h1);
        check("t1_gnt_off", 32'(tmr.gnt), 32'h0);
        check("t1_busy_done", 32'(tmr.busy), 32'h1);
        tmr.req = '0;
        nxt();
        check("t1_idle_busy", 32'(tmr.busy), 32'h0);

        // All requesters, interval 1: rotation from pointer 0
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        glog.delete();
        gtime.delete();
        for (int i = 0; i < NREQ; i++) set_cnt(i, 1);
        tmr.req = 4'b1111;
        repeat (18) nxt();
        tmr.req = '0;
        repeat (3) nxt();
        check("t2_ngnt", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5 && i < glog.size(); i++) check("t2_order", 32'(glog[i]), 32'(exp_order[i]));
        for (int i = 0; i < 4 && i + 1 < gtime.size(); i++) check("t2_gap", 32'(gtime[i+1] - gtime[i]), 32'd4);

        // Abort on requester 2 in its 4th RUN cycle
        set_cnt(2, 10);
        tmr.req = 4'b0100;
        wait_gnt(2);
        check("t3_cur0", 32'(tmr.cur_cnt), 32'd10);
        d0 = done_seen;
        repeat (3) nxt();
        check("t3_cur3", 32'(tmr.cur_cnt), 32'd7);
        tmr.req = '0;
        nxt();
        check("t3_busy", 32'(tmr.busy), 32'd0);
        check("t3_gnt",  32'(tmr.gnt),  32'd0);
        check("t3_cur",  32'(tmr.cur_cnt), 32'd0);
        nxt();
        check("t3_nodone", 32'(done_seen), 32'(d0));

        // Zero interval on requester 1
        set_cnt(1, 0);
        tmr.req = 4'b0010;
        wait_gnt(1);
        check("t4_cur", 32'(tmr.cur_cnt), 32'd0);
        nxt();
        check("t4_done", 32'(tmr.done), 32'h2);
        check("t4_gnt",  32'(tmr.gnt),  32'h0);
        tmr.req = '0;
        nxt();
        check("t4_idle", 32'(tmr.busy), 32'd0);

        // Asynchronous reset in the middle of a RUN
        set_cnt(3, 20);
        tmr.req = 4'b1000;
        wait_gnt(3);
        repeat (2) nxt();
        #2 rst = 1'b1;
        #1;
        check("t5_gnt",  32'(tmr.gnt),     32'd0);
        check("t5_busy", 32'(tmr.busy),    32'd0);
        check("t5_cur",  32'(tmr.cur_cnt), 32'd0);
        check("t5_done", 32'(tmr.done),    32'd0);
        nxt();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_cnt(i, 2);
        tmr.req = 4'b1111;
        wait_gnt(0);
        check("t5_winner", 32'(tmr.gnt), 32'h1);
        tmr.req = '0;
        repeat (3) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
